// File: rtl/decoder_round_scheduler_pkg.sv
// Shared stage-controller encodings and round scheduler state encodings.
package decoder_round_scheduler_pkg;

   localparam int STAGE_WIDTH = 3;

   localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
   localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
   localparam logic [STAGE_WIDTH-1:0] STAGE_SPREAD              = 3'd2;
   localparam logic [STAGE_WIDTH-1:0] STAGE_SYNDROME_VALIDATION = 3'd3;
   localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4;

   typedef enum logic [1:0] {
      SCHED_IDLE,
      SCHED_START,
      SCHED_WAIT_BUSY,
      SCHED_WAIT_RESULT
   } sched_state_t;

endpackage

// File: rtl/decoder_round_scheduler_saturating_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module saturating_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset || clear)
         count <= '0;
      else if (inc && !(&count))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/decoder_round_scheduler.sv
// Issues decoding rounds to the stage controller and captures one
// result record per round into a single-entry output slot.
module decoder_round_scheduler
   import decoder_round_scheduler_pkg::*;
#(
   parameter int          ITERATION_COUNTER_WIDTH = 8,
   parameter int          ROUND_ID_WIDTH          = 8,
   parameter int unsigned WATCHDOG_CYCLES         = 4096,
   parameter int          STAT_WIDTH              = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               round_valid,
   input  logic [ROUND_ID_WIDTH-1:0]          round_id,
   output logic                               round_ready,
   output logic                               new_round_start,
   input  logic [STAGE_WIDTH-1:0]             stage,
   input  logic                               result_valid,
   input  logic                               deadlock,
   input  logic                               final_cardinality,
   input  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
   input  logic [31:0]                        cycle_counter,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [ROUND_ID_WIDTH-1:0]          out_round_id,
   output logic                               out_cardinality,
   output logic [ITERATION_COUNTER_WIDTH-1:0] out_iterations,
   output logic [31:0]                        out_cycles,
   output logic                               out_deadlock,
   output logic                               out_timeout,
   output logic                               busy,
   output logic [STAT_WIDTH-1:0]              rounds_done,
   output logic [STAT_WIDTH-1:0]              deadlock_count
);

   localparam int WD_W =
      (WATCHDOG_CYCLES > 2) ? $clog2(WATCHDOG_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_FIRE = WD_W'(WATCHDOG_CYCLES - 2);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WATCHDOG_CYCLES - 1);

   sched_state_t              state;
   logic [ROUND_ID_WIDTH-1:0] cur_id;
   logic [WD_W-1:0]           wd;

   logic stage_idle;
   logic slot_free;
   logic wd_fire;
   logic term;
   logic cap;
   logic cap_dl;
   logic cap_to;

   assign stage_idle  = (stage == STAGE_IDLE);
   assign slot_free   = !out_valid || out_ready;
   // wd is about to reach WATCHDOG_CYCLES-1 on this edge
   assign wd_fire     = (wd >= WD_FIRE);
   assign round_ready = !reset && (state == SCHED_IDLE) && stage_idle;
   assign busy        = (state != SCHED_IDLE);

   always_comb begin
      term   = 1'b0;
      cap_to = 1'b0;
      unique case (state)
         SCHED_WAIT_BUSY: cap_to = wd_fire;
         SCHED_WAIT_RESULT: begin
            term   = stage_idle && (result_valid || deadlock);
            cap_to = !term && wd_fire;
         end
         default: ;
      endcase
      cap    = slot_free && (term || cap_to);
      cap_dl = term && deadlock && !result_valid;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= SCHED_IDLE;
         new_round_start <= 1'b0;
         cur_id          <= '0;
         wd              <= '0;
         out_valid       <= 1'b0;
         out_round_id    <= '0;
         out_cardinality <= 1'b0;
         out_iterations  <= '0;
         out_cycles      <= '0;
         out_deadlock    <= 1'b0;
         out_timeout     <= 1'b0;
      end else begin
         new_round_start <= 1'b0;

         if (cap) begin
            out_valid       <= 1'b1;
            out_round_id    <= cur_id;
            out_cardinality <= final_cardinality;
            out_iterations  <= iteration_counter;
            out_cycles      <= cycle_counter;
            out_deadlock    <= cap_dl;
            out_timeout     <= cap_to;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         unique case (state)
            SCHED_IDLE: begin
               if (round_valid && round_ready) begin
                  cur_id          <= round_id;
                  new_round_start <= 1'b1;
                  state           <= SCHED_START;
               end
            end
            SCHED_START: begin
               wd    <= '0;
               state <= SCHED_WAIT_BUSY;
            end
            SCHED_WAIT_BUSY: begin
               if (wd != WD_MAX)
                  wd <= wd + 1'b1;
               // stale result_valid from the last round is ignored here
               if (cap)
                  state <= SCHED_IDLE;
               else if (!stage_idle)
                  state <= SCHED_WAIT_RESULT;
            end
            SCHED_WAIT_RESULT: begin
               if (wd != WD_MAX)
                  wd <= wd + 1'b1;
               if (cap)
                  state <= SCHED_IDLE;
            end
         endcase
      end
   end

   saturating_counter #(.WIDTH(STAT_WIDTH)) u_rounds_done (
      .clk   (clk),
      .reset (reset),
      .inc   (cap),
      .clear (1'b0),
      .count (rounds_done)
   );

   saturating_counter #(.WIDTH(STAT_WIDTH)) u_deadlock_count (
      .clk   (clk),
      .reset (reset),
      .inc   (cap && (cap_dl || cap_to)),
      .clear (1'b0),
      .count (deadlock_count)
   );

endmodule

// File: tb/tb_decoder_round_scheduler.sv
// Directed bench for decoder_round_scheduler with a scripted stage model.
module tb_decoder_round_scheduler;
   import decoder_round_scheduler_pkg::*;

   logic                   clk;
   logic                   reset;
   logic                   round_valid;
   logic [7:0]             round_id;
   logic                   round_ready;
   logic                   new_round_start;
   logic [STAGE_WIDTH-1:0] stage;
   logic                   result_valid;
   logic                   deadlock;
   logic                   final_cardinality;
   logic [7:0]             iteration_counter;
   logic [31:0]            cycle_counter;
   logic                   out_valid;
   logic                   out_ready;
   logic [7:0]             out_round_id;
   logic                   out_cardinality;
   logic [7:0]             out_iterations;
   logic [31:0]            out_cycles;
   logic                   out_deadlock;
   logic                   out_timeout;
   logic                   busy;
   logic [15:0]            rounds_done;
   logic [15:0]            deadlock_count;

   decoder_round_scheduler #(
      .ITERATION_COUNTER_WIDTH (8),
      .ROUND_ID_WIDTH          (8),
      .WATCHDOG_CYCLES         (16),
      .STAT_WIDTH              (16)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .round_valid       (round_valid),
      .round_id          (round_id),
      .round_ready       (round_ready),
      .new_round_start   (new_round_start),
      .stage             (stage),
      .result_valid      (result_valid),
      .deadlock          (deadlock),
      .final_cardinality (final_cardinality),
      .iteration_counter (iteration_counter),
      .cycle_counter     (cycle_counter),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_round_id      (out_round_id),
      .out_cardinality   (out_cardinality),
      .out_iterations    (out_iterations),
      .out_cycles        (out_cycles),
      .out_deadlock      (out_deadlock),
      .out_timeout       (out_timeout),
      .busy              (busy),
      .rounds_done       (rounds_done),
      .deadlock_count    (deadlock_count)
   );

   typedef struct {
      logic [7:0]  id;
      logic        card;
      logic [7:0]  iters;
      logic [31:0] cyc;
      logic        rv;
      logic        dl;
      int          busy_len;
      int          stale;
      logic        exp_dl;
      int          exp_rounds;
      int          exp_dlc;
   } vec_t;

   vec_t tbl [5];

   int errors = 0;
   int checks = 0;
   int pulses = 0;
   int hs = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (new_round_start) pulses <= pulses + 1;
      if (out_valid && out_ready) hs <= hs + 1;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_ready(input string nm);
      int n;
      n = 0;
      #1;
      while (!round_ready && n < 40) begin
         tick();
         n++;
      end
      chk({nm, "_accept_bound"}, 64'(n < 40), 64'd1);
   endtask

   task automatic run_round(input string nm, input vec_t v);
      int p0;
      int r0;
      round_valid = 1'b1;
      round_id    = v.id;
      wait_ready(nm);
      p0 = pulses;
      tick();
      round_valid = 1'b0;
      chk({nm, "_pulse"}, 64'(new_round_start), 64'd1);
      chk({nm, "_busy"}, 64'(busy), 64'd1);
      tick();
      r0 = int'(rounds_done);
      for (int i = 0; i < v.stale; i++) begin
         tick();
         chk({nm, "_stale_nocap"}, 64'(rounds_done), 64'(r0));
      end
      stage        = STAGE_MEASUREMENT_LOADING;
      result_valid = 1'b0;
      deadlock     = 1'b0;
      for (int i = 0; i < v.busy_len; i++) begin
         tick();
         stage = STAGE_SPREAD;
      end
      stage             = STAGE_IDLE;
      result_valid      = v.rv;
      deadlock          = v.dl;
      final_cardinality = v.card;
      iteration_counter = v.iters;
      cycle_counter     = v.cyc;
      tick();
      chk({nm, "_out_valid"}, 64'(out_valid), 64'd1);
      chk({nm, "_id"}, 64'(out_round_id), 64'(v.id));
      chk({nm, "_card"}, 64'(out_cardinality), 64'(v.card));
      chk({nm, "_iters"}, 64'(out_iterations), 64'(v.iters));
      chk({nm, "_cycles"}, 64'(out_cycles), 64'(v.cyc));
      chk({nm, "_dl"}, 64'(out_deadlock), 64'(v.exp_dl));
      chk({nm, "_to"}, 64'(out_timeout), 64'd0);
      chk({nm, "_rounds"}, 64'(rounds_done), 64'(v.exp_rounds));
      chk({nm, "_dlc"}, 64'(deadlock_count), 64'(v.exp_dlc));
      chk({nm, "_one_pulse"}, 64'(pulses - p0), 64'd1);
   endtask

   task automatic chk_reset_state(input string nm);
      chk({nm, "_ready"}, 64'(round_ready), 64'd0);
      chk({nm, "_start"}, 64'(new_round_start), 64'd0);
      chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({nm, "_fields"},
          {out_round_id, out_cardinality, out_iterations, out_cycles,
           out_deadlock, out_timeout}, 64'd0);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_rounds"}, 64'(rounds_done), 64'd0);
      chk({nm, "_dlc"}, 64'(deadlock_count), 64'd0);
   endtask

   initial begin
      int h0;
      int p0;

      tbl[0] = '{8'h05, 1'b1, 8'd3, 32'd42, 1'b1, 1'b0, 4, 0, 1'b0, 1, 0};
      tbl[1] = '{8'h11, 1'b0, 8'd7, 32'd100, 1'b0, 1'b1, 3, 3, 1'b1, 2, 1};
      tbl[2] = '{8'hA5, 1'b1, 8'hFF, 32'hDEADBEEF, 1'b1, 1'b1, 2, 0,
                 1'b0, 3, 1};
      tbl[3] = '{8'h00, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1, 1, 1'b0, 4, 1};
      tbl[4] = '{8'hFF, 1'b1, 8'd1, 32'hFFFFFFFF, 1'b0, 1'b1, 5, 0,
                 1'b1, 5, 2};

      reset             = 1'b1;
      round_valid       = 1'b1;
      round_id          = 8'h99;
      stage             = STAGE_IDLE;
      result_valid      = 1'b0;
      deadlock          = 1'b0;
      final_cardinality = 1'b0;
      iteration_counter = '0;
      cycle_counter     = '0;
      out_ready         = 1'b1;
      tick();
      tick();
      chk_reset_state("reset");
      reset       = 1'b0;
      round_valid = 1'b0;
      tick();

      for (int i = 0; i < 5; i++)
         run_round($sformatf("vec%0d", i), tbl[i]);

      // watchdog: stage stuck in SPREAD
      round_valid = 1'b1;
      round_id    = 8'h33;
      wait_ready("wd");
      tick();
      round_valid = 1'b0;
      chk("wd_pulse", 64'(new_round_start), 64'd1);
      tick();
      stage             = STAGE_SPREAD;
      result_valid      = 1'b0;
      deadlock          = 1'b0;
      final_cardinality = 1'b0;
      iteration_counter = 8'd9;
      cycle_counter     = 32'd77;
      for (int i = 2; i <= 15; i++) tick();
      chk("wd_early", 64'(out_valid), 64'd0);
      tick();
      chk("wd_out_valid", 64'(out_valid), 64'd1);
      chk("wd_to", 64'(out_timeout), 64'd1);
      chk("wd_dl", 64'(out_deadlock), 64'd0);
      chk("wd_id", 64'(out_round_id), 64'h33);
      chk("wd_iters", 64'(out_iterations), 64'd9);
      chk("wd_cycles", 64'(out_cycles), 64'd77);
      chk("wd_rounds", 64'(rounds_done), 64'd6);
      chk("wd_dlc", 64'(deadlock_count), 64'd3);
      p0          = pulses;
      round_valid = 1'b1;
      round_id    = 8'h34;
      for (int i = 0; i < 3; i++) begin
         chk("wd_ready_low", 64'(round_ready), 64'd0);
         tick();
      end
      chk("wd_no_start", 64'(pulses - p0), 64'd0);
      chk("wd_idle", 64'(busy), 64'd0);
      round_valid = 1'b0;
      stage       = STAGE_IDLE;
      #1;
      chk("wd_ready_back", 64'(round_ready), 64'd1);
      tick();

      // back-pressure: two rounds complete while the consumer stalls
      out_ready = 1'b0;
      h0        = hs;
      run_round("bpA", '{8'h21, 1'b1, 8'd2, 32'd20, 1'b1, 1'b0, 2, 0,
                         1'b0, 7, 3});
      round_valid = 1'b1;
      round_id    = 8'h22;
      #1;
      chk("bp_ready_pipelined", 64'(round_ready), 64'd1);
      tick();
      round_valid = 1'b0;
      chk("bp_pulse", 64'(new_round_start), 64'd1);
      tick();
      stage        = STAGE_MEASUREMENT_LOADING;
      result_valid = 1'b0;
      tick();
      tick();
      stage             = STAGE_IDLE;
      result_valid      = 1'b1;
      final_cardinality = 1'b0;
      iteration_counter = 8'd4;
      cycle_counter     = 32'd55;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold_id", 64'(out_round_id), 64'h21);
         chk("bp_hold_busy", 64'(busy), 64'd1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_id", 64'(out_round_id), 64'h22);
      chk("bp_iters", 64'(out_iterations), 64'd4);
      chk("bp_cycles", 64'(out_cycles), 64'd55);
      chk("bp_rounds", 64'(rounds_done), 64'd8);
      tick();
      chk("bp_stable", 64'(out_round_id), 64'h22);
      chk("bp_done", 64'(busy), 64'd0);
      out_ready = 1'b1;
      tick();
      chk("bp_drained", 64'(out_valid), 64'd0);
      tick();
      chk("bp_no_dup", 64'(out_valid), 64'd0);
      chk("bp_handshakes", 64'(hs - h0), 64'd2);

      // reset in the middle of WAIT_RESULT with a full slot
      out_ready = 1'b0;
      run_round("rsA", '{8'h43, 1'b0, 8'd6, 32'd31, 1'b1, 1'b0, 1, 0,
                         1'b0, 9, 3});
      round_valid = 1'b1;
      round_id    = 8'h44;
      wait_ready("rs");
      tick();
      round_valid = 1'b0;
      tick();
      stage        = STAGE_MEASUREMENT_LOADING;
      result_valid = 1'b0;
      tick();
      tick();
      chk("rs_busy_before", 64'(busy), 64'd1);
      reset        = 1'b1;
      round_valid  = 1'b1;
      stage        = STAGE_IDLE;
      tick();
      chk_reset_state("rs");
      reset       = 1'b0;
      round_valid = 1'b0;
      out_ready   = 1'b1;
      tick();
      run_round("rsB", '{8'h46, 1'b1, 8'd12, 32'd300, 1'b1, 1'b0, 3, 0,
                         1'b0, 1, 0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decoder_round_scheduler.md
# decoder_round_scheduler

Sequences decoding rounds through `decoder_stage_controller`. It accepts round requests through a valid/ready handshake and pulses `new_round_start`. It then tracks the stage machine to completion, deadlock or watchdog timeout, and emits a per-round result record through a one-deep output slot. The block sits between the syndrome/measurement front end and the result consumer, and is the only driver of `new_round_start`.

## Interface
- `ITERATION_COUNTER_WIDTH`, default 8: width of the captured iteration count; must match the stage controller.
- `ROUND_ID_WIDTH`, default 8: width of the round tag.
- `WATCHDOG_CYCLES`, default 4096: cycles from start pulse to forced timeout; must be ≥2.
- `STAT_WIDTH`, default 16: width of the saturating statistics counters.
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `round_valid`, in, 1: a round request is present.
- `round_id`, in, `ROUND_ID_WIDTH`: tag of the requested round.
- `round_ready`, out, 1: the request is accepted this cycle.
- `new_round_start`, out, 1: one-cycle pulse to the stage controller.
- `stage`, in, `STAGE_WIDTH`: stage from the stage controller.
- `result_valid`, in, 1: result valid from the stage controller.
- `deadlock`, in, 1: deadlock flag from the stage controller.
- `final_cardinality`, in, 1: final cardinality from the stage controller.
- `iteration_counter`, in, `ITERATION_COUNTER_WIDTH`: iteration count from the stage controller.
- `cycle_counter`, in, 32: cycle count from the stage controller.
- `out_valid`, out, 1: the result slot is occupied.
- `out_ready`, in, 1: the consumer accepts the slot.
- `out_round_id`, out, `ROUND_ID_WIDTH`: tag of the reported round.
- `out_cardinality`, out, 1: captured final cardinality.
- `out_iterations`, out, `ITERATION_COUNTER_WIDTH`: captured iteration count.
- `out_cycles`, out, 32: captured cycle count.
- `out_deadlock`, out, 1: the round ended in deadlock.
- `out_timeout`, out, 1: the round ended by watchdog timeout.
- `busy`, out, 1: the FSM is not in S_IDLE.
- `rounds_done`, out, `STAT_WIDTH`: completed rounds, saturating.
- `deadlock_count`, out, `STAT_WIDTH`: deadlock and timeout rounds, saturating.

## Operation
- **FSM states:** S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_RESULT.
- **S_IDLE:**
  - `round_ready` = (`stage`==STAGE_IDLE) && !`out_valid_pending_capture`.
  - `out_valid_pending_capture` means a result is still awaiting capture. It is structurally 0 in S_IDLE, so `round_ready` reduces to `stage`==STAGE_IDLE.
  - On `round_valid`&&`round_ready`, latch `round_id` into `cur_id` and go to S_START.
- **S_START:** assert `new_round_start` for exactly this cycle, clear the watchdog, go to S_WAIT_BUSY.
- **S_WAIT_BUSY:** wait for `stage`!=STAGE_IDLE, then go to S_WAIT_RESULT. This wait is mandatory: the previous round's `result_valid` stays high until loading begins.
- **S_WAIT_RESULT:** the terminating condition is `stage`==STAGE_IDLE && (`result_valid` || `deadlock`).
  - If the output slot is free, or is being drained this cycle (`out_valid`&&`out_ready`), capture on that cycle and return to S_IDLE.
  - Capture writes `cur_id`, `final_cardinality`, `iteration_counter`, `cycle_counter`, and `out_deadlock`=`deadlock` && !`result_valid`.
  - If the slot is blocked, stay in S_WAIT_RESULT. The stage controller holds its result until the next start pulse, and none is issued while waiting.
- **Watchdog:**
  - Counts every cycle in S_WAIT_BUSY and S_WAIT_RESULT.
  - On reaching `WATCHDOG_CYCLES`-1 with no terminating condition, capture with `out_timeout`=1. Cardinality, iterations and cycles are captured as the current input values.
  - Capture obeys the same slot-free rule as above.
- **Pipelining:** a held output slot does not block S_IDLE → S_START. Only a second capture is blocked.
- **Output slot:**
  - `out_valid` is set on capture and cleared on `out_valid`&&`out_ready` unless a capture occurs in the same cycle, in which case it stays 1 with the new data.
  - Fields are stable while `out_valid`&&!`out_ready`.
- **Statistics:**
  - `rounds_done` increments on every capture.
  - `deadlock_count` increments on captures with `out_deadlock` or `out_timeout`.
  - Both saturate at all-ones.

## Timing
- **Reset values:** FSM=S_IDLE; `new_round_start`=0; `round_ready`=0 during the reset cycle; `out_valid`=0; all `out_*` fields=0; watchdog=0; both statistics counters=0; `busy`=0.
- **Latency:** request acceptance → `new_round_start` is 1 cycle. The stage controller reaches STAGE_MEASUREMENT_LOADING 1 cycle after the pulse.
- **Capture:** the terminating condition seen at edge N gives `out_valid`=1 after edge N.
- **Minimum gap between rounds:** S_IDLE→S_START→S_WAIT_BUSY→S_WAIT_RESULT→S_IDLE, i.e. one request per ≥4 cycles.
- **Reset mid-round:** the FSM returns to S_IDLE and the slot is cleared. The stage controller shares `reset` and returns to STAGE_IDLE in the same cycle.
- `round_valid` may drop without acceptance; there is no stickiness requirement on the requester.

## Structure
- STAGE_* encodings and `STAGE_WIDTH` come from the shared parameters package.
- Scheduler state encodings are added there too, as a localparam enum: SCHED_IDLE, SCHED_START, SCHED_WAIT_BUSY, SCHED_WAIT_RESULT.
- The watchdog, FSM and slot are inline. The saturating counter is a natural sub-module, `saturating_counter #(WIDTH)` with `inc` and `clear`, instantiated twice.

## Test plan
- **Normal round:** `round_valid`, id=0x05; the stage model passes LOADING→…→IDLE with `result_valid`=1, cardinality=1, iterations=3, cycles=42 → a single `new_round_start` pulse, then `out_valid` with {0x05, 1, 3, 42, dl=0, to=0}; `rounds_done`=1.
- **Stale result ignored:** the previous round left `result_valid`=1 and the stage model delays leaving IDLE by 3 cycles → no capture until after `stage` leaves and returns to IDLE.
- **Deadlock:** the stage model returns to IDLE with `deadlock`=1 and `result_valid`=0 → `out_deadlock`=1; `deadlock_count`=1.
- **Watchdog:** `WATCHDOG_CYCLES`=16 and the stage model is stuck in SPREAD → `out_timeout`=1 exactly 16 cycles after the start pulse, and `round_ready` stays 0 until `stage`=IDLE.
- **Back-pressure:** `out_ready`=0 while two rounds complete → round 2 is started, its capture waits, and after `out_ready`=1 for one cycle the slot shows round 2 data with no record lost or duplicated.
- **Reset mid-WAIT_RESULT:** → all outputs at reset values next cycle, and a subsequent round completes normally.
